// File: rtl/wdt_windowed.sv
// ============================================================================
// Module   : wdt_windowed
// Brief    : Windowed watchdog timer with a byte-wide CSR port. Optional
//            pretimeout interrupt is compiled in with WDT_PRETIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wdt_windowed #(
    parameter int          CNT_WIDTH   = 16,
    parameter logic [15:0] DFL_TIMEOUT = 16'h0003,
    parameter logic        DFL_EN      = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] csr_a,
    input  logic [7:0] csr_di,
    input  logic       csr_we,
    output logic [7:0] csr_do,
    input  logic       wdt_ce,
    output logic       wdt_rst,
    output logic       wdt_irq
);

    localparam logic [4:0] c_A_CTRL   = 5'h00;
    localparam logic [4:0] c_A_KICK   = 5'h01;
    localparam logic [4:0] c_A_TO_LO  = 5'h02;
    localparam logic [4:0] c_A_TO_HI  = 5'h03;
    localparam logic [4:0] c_A_WIN_LO = 5'h04;
    localparam logic [4:0] c_A_WIN_HI = 5'h05;
    localparam logic [4:0] c_A_PRETO  = 5'h06;
    localparam logic [4:0] c_A_STATUS = 5'h07;
    localparam logic [7:0] c_KICK_KEY = 8'h6B;
    localparam logic [CNT_WIDTH-1:0] c_DFL_TO = DFL_TIMEOUT[CNT_WIDTH-1:0];
    localparam logic [CNT_WIDTH-1:0] c_ONE    = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic                 r_en;
    logic                 r_lock;
    logic                 r_wmode;
    logic                 r_irq_en;
    logic [CNT_WIDTH-1:0] r_timeout;
    logic [CNT_WIDTH-1:0] r_window;
    logic [7:0]           r_to_shadow;
    logic [7:0]           r_win_shadow;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [3:0]           r_status;

    logic                 w_wr_ctrl;
    logic                 w_wr_kick;
    logic                 w_wr_status;
    logic                 w_good_kick;
    logic                 w_bad_kick;
    logic                 w_early;
    logic                 w_tmo;
    logic                 w_fire;
    logic                 w_en_rise;
    logic                 w_reload;
    logic                 w_dec;
    logic                 w_irq_set;
    logic [CNT_WIDTH-1:0] w_cnt_dec;
    logic [15:0]          w_to_commit;
    logic [15:0]          w_win_commit;
    logic [15:0]          w_to16;
    logic [15:0]          w_win16;
    logic [7:0]           w_preto_rd;
    logic [3:0]           w_status_set;
    logic [3:0]           w_status_clr;
    logic [3:0]           w_status_nxt;
    logic [7:0]           w_rdata;

    assign w_wr_ctrl   = csr_we && (csr_a == c_A_CTRL) && !r_lock;
    assign w_wr_kick   = csr_we && (csr_a == c_A_KICK);
    assign w_wr_status = csr_we && (csr_a == c_A_STATUS);

    // Any KICK write, good or bad, pre-empts a coincident cnt==0 timeout
    assign w_good_kick = w_wr_kick && (csr_di == c_KICK_KEY);
    assign w_bad_kick  = w_wr_kick && (csr_di != c_KICK_KEY) && r_en;
    assign w_early     = w_good_kick && r_en && r_wmode && (r_cnt > r_window);
    assign w_tmo       = wdt_ce && r_en && (r_cnt == '0) && !w_wr_kick;
    assign w_fire      = w_tmo || w_early || w_bad_kick;
    assign w_en_rise   = w_wr_ctrl && csr_di[0] && !r_en;
    assign w_reload    = w_good_kick || w_fire || w_en_rise;
    assign w_dec       = wdt_ce && r_en && (r_cnt != '0) && !w_reload;
    assign w_cnt_dec   = r_cnt - c_ONE;

    assign w_to_commit  = {csr_di, r_to_shadow};
    assign w_win_commit = {csr_di, r_win_shadow};
    assign w_to16       = 16'(r_timeout);
    assign w_win16      = 16'(r_window);

    assign w_status_set = {w_irq_set, w_bad_kick, w_early, w_tmo};
    assign w_status_clr = w_wr_status ? csr_di[3:0] : 4'h0;
    assign w_status_nxt = w_status_set | (r_status & ~w_status_clr);

    always_comb begin
        w_rdata = 8'h00;
        case (csr_a)
            c_A_CTRL:   w_rdata = {4'h0, r_irq_en, r_wmode, r_lock, r_en};
            c_A_TO_LO:  w_rdata = w_to16[7:0];
            c_A_TO_HI:  w_rdata = w_to16[15:8];
            c_A_WIN_LO: w_rdata = w_win16[7:0];
            c_A_WIN_HI: w_rdata = w_win16[15:8];
            c_A_PRETO:  w_rdata = w_preto_rd;
            c_A_STATUS: w_rdata = {4'h0, r_status};
            default:    w_rdata = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en         <= DFL_EN;
            r_lock       <= 1'b0;
            r_wmode      <= 1'b0;
            r_irq_en     <= 1'b0;
            r_timeout    <= c_DFL_TO;
            r_window     <= '1;
            r_to_shadow  <= 8'h00;
            r_win_shadow <= 8'h00;
            r_cnt        <= c_DFL_TO;
            r_status     <= 4'h0;
            csr_do       <= 8'h00;
            wdt_rst      <= 1'b0;
        end else begin
            if (w_wr_ctrl) begin
                r_en     <= csr_di[0];
                r_lock   <= csr_di[1];
                r_wmode  <= csr_di[2];
                r_irq_en <= csr_di[3];
            end
            if (csr_we && !r_lock) begin
                if (csr_a == c_A_TO_LO)  r_to_shadow  <= csr_di;
                if (csr_a == c_A_TO_HI)  r_timeout    <= w_to_commit[CNT_WIDTH-1:0];
                if (csr_a == c_A_WIN_LO) r_win_shadow <= csr_di;
                if (csr_a == c_A_WIN_HI) r_window     <= w_win_commit[CNT_WIDTH-1:0];
            end
            if (w_reload)
                r_cnt <= r_timeout;
            else if (w_dec)
                r_cnt <= w_cnt_dec;
            r_status <= w_status_nxt;
            csr_do   <= w_rdata;
            wdt_rst  <= w_fire;
        end
    end

`ifdef WDT_PRETIMEOUT_EN
    logic [7:0] r_preto;

    assign w_preto_rd = r_preto;
    assign w_irq_set  = w_dec && (r_preto != 8'h00) && (w_cnt_dec == CNT_WIDTH'(r_preto));

    // Uses next-state values so the pin tracks STATUS.IRQ without extra lag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_preto <= 8'h00;
            wdt_irq <= 1'b0;
        end else begin
            if (csr_we && !r_lock && (csr_a == c_A_PRETO))
                r_preto <= csr_di;
            wdt_irq <= w_status_nxt[3] & (w_wr_ctrl ? csr_di[3] : r_irq_en);
        end
    end
`else
    assign w_preto_rd = 8'h00;
    assign w_irq_set  = 1'b0;
    assign wdt_irq    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wdt_windowed.sv
// ============================================================================
// Module   : tb_wdt_windowed
// Brief    : Scoreboard bench for wdt_windowed; CSR reads and wdt_rst pulses
//            are queued by stimulus and consumed by independent monitors.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wdt_windowed;

    logic       clk;
    logic       rst;
    logic [4:0] csr_a;
    logic [7:0] csr_di;
    logic       csr_we;
    logic [7:0] csr_do;
    logic       wdt_ce;
    logic       wdt_rst;
    logic       wdt_irq;

    int         n_vec;
    int         n_bad;
    int         cyc;
    logic       rd_req;
    logic       mon_valid;

    string      rd_name_q[$];
    logic [7:0] rd_exp_q[$];
    string      p_name_q[$];
    int         p_cyc_q[$];

    wdt_windowed dut (
        .clk     (clk),
        .rst     (rst),
        .csr_a   (csr_a),
        .csr_di  (csr_di),
        .csr_we  (csr_we),
        .csr_do  (csr_do),
        .wdt_ce  (wdt_ce),
        .wdt_rst (wdt_rst),
        .wdt_irq (wdt_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        mon_valid <= rd_req;
    end

    // Read monitor: csr_do is valid one clk after the address was presented
    always @(negedge clk) begin
        if (mon_valid) begin
            n_vec++;
            if (rd_exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: csr_do=0x%02h with no read queued", csr_do);
            end else begin
                string      nm;
                logic [7:0] ex;
                nm = rd_name_q.pop_front();
                ex = rd_exp_q.pop_front();
                if (csr_do !== ex) begin
                    n_bad++;
                    $display("FAIL %s: csr_do=0x%02h expected 0x%02h", nm, csr_do, ex);
                end
            end
        end
    end

    // Pulse monitor: every wdt_rst sample must match a queued pulse at its cycle
    always @(negedge clk) begin
        if (wdt_rst) begin
            n_vec++;
            if (p_cyc_q.size() == 0) begin
                n_bad++;
                $display("FAIL rst_unexpected: wdt_rst=1 at cycle %0d, none expected", cyc);
            end else begin
                string nm;
                int    ec;
                nm = p_name_q.pop_front();
                ec = p_cyc_q.pop_front();
                if (ec != cyc) begin
                    n_bad++;
                    $display("FAIL %s: wdt_rst at cycle %0d expected cycle %0d", nm, cyc, ec);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic chk(input string nm, input logic act, input logic ex);
        n_vec++;
        if (act !== ex) begin
            n_bad++;
            $display("FAIL %s: got %0b expected %0b", nm, act, ex);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
    endtask

    task automatic wr_ce(input logic [4:0] a, input logic [7:0] d);
        csr_a  = a;
        csr_di = d;
        csr_we = 1'b1;
        wdt_ce = 1'b1;
        @(negedge clk);
        csr_we = 1'b0;
        wdt_ce = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [7:0] e, input string nm);
        csr_a = a;
        rd_name_q.push_back(nm);
        rd_exp_q.push_back(e);
        rd_req = 1'b1;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic exp_pulse(input string nm);
        p_name_q.push_back(nm);
        p_cyc_q.push_back(cyc + 1);
    endtask

    task automatic ces(input int n);
        for (int i = 0; i < n; i++) begin
            wdt_ce = 1'b1;
            @(negedge clk);
            wdt_ce = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_vec = 0; n_bad = 0; cyc = 0;
        rd_req = 1'b0; mon_valid = 1'b0;
        csr_a = 5'h00; csr_di = 8'h00; csr_we = 1'b0; wdt_ce = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        do_reset(3);

        // Reset values
        chk("rst_do", csr_do[0], 1'b0);
        rd(5'h00, 8'h00, "rst_ctrl");
        rd(5'h02, 8'h03, "rst_to_lo");
        rd(5'h03, 8'h00, "rst_to_hi");
        rd(5'h04, 8'hFF, "rst_win_lo");
        rd(5'h05, 8'hFF, "rst_win_hi");
        rd(5'h06, 8'h00, "rst_preto");
        rd(5'h07, 8'h00, "rst_status");
        wr(5'h1F, 8'hFF);
        rd(5'h1F, 8'h00, "unmapped");

        // Enable, no kicks, slow tick every 100 clk: timeout on the 4th tick
        wr(5'h00, 8'h01);
        for (int i = 0; i < 4; i++) begin
            repeat (99) @(negedge clk);
            if (i == 3) exp_pulse("basic_timeout");
            wdt_ce = 1'b1;
            @(negedge clk);
            wdt_ce = 1'b0;
        end
        @(negedge clk);
        rd(5'h07, 8'h01, "basic_status");
        wr(5'h07, 8'h01);
        rd(5'h07, 8'h00, "status_w1c");

        // Shadowed TIMEOUT commit
        wr(5'h02, 8'h10);
        rd(5'h02, 8'h03, "to_shadow_hidden");
        wr(5'h03, 8'h00);
        rd(5'h02, 8'h10, "to_committed_lo");
        rd(5'h03, 8'h00, "to_committed_hi");

        // Bad kick enabled then disabled
        exp_pulse("bad_kick");
        wr(5'h01, 8'h55);
        rd(5'h07, 8'h04, "bad_status");
        wr(5'h07, 8'h04);
        wr(5'h00, 8'h00);
        wr(5'h01, 8'h55);
        rd(5'h07, 8'h00, "bad_kick_disabled");

        // Window mode: TIMEOUT=5, WINDOW=2
        wr(5'h02, 8'h05); wr(5'h03, 8'h00);
        wr(5'h04, 8'h02); wr(5'h05, 8'h00);
        rd(5'h04, 8'h02, "win_lo");
        wr(5'h00, 8'h05);
        ces(1);
        exp_pulse("early_kick");
        wr(5'h01, 8'h6B);
        rd(5'h07, 8'h02, "early_status");
        wr(5'h07, 8'h02);
        ces(3);
        wr(5'h01, 8'h6B);
        rd(5'h07, 8'h00, "in_window_kick");
        ces(5);
        exp_pulse("reload_after_kick");
        ces(1);
        rd(5'h07, 8'h01, "window_to_status");
        wr(5'h07, 8'h01);

        // Kick coincident with cnt==0 tick suppresses the timeout
        ces(5);
        wr_ce(5'h01, 8'h6B);
        rd(5'h07, 8'h00, "kick_suppress");
        ces(5);
        exp_pulse("after_suppress");
        ces(1);
        wr(5'h07, 8'h01);

        // Set beats write-1-to-clear on the same clk
        ces(5);
        exp_pulse("set_vs_clear");
        wr_ce(5'h07, 8'h01);
        rd(5'h07, 8'h01, "set_wins");
        wr(5'h07, 8'h01);

        // Lock
        wr(5'h00, 8'h03);
        rd(5'h00, 8'h03, "lock_ctrl");
        wr(5'h00, 8'h00);
        rd(5'h00, 8'h03, "lock_holds");
        wr(5'h02, 8'h09); wr(5'h03, 8'h00);
        rd(5'h02, 8'h05, "lock_to");
        ces(5);
        exp_pulse("lock_counting");
        ces(1);
        rd(5'h07, 8'h01, "lock_status");

        // Reset mid-count: no pulse, lock cleared
        ces(2);
        do_reset(2);
        rd(5'h00, 8'h00, "rst2_ctrl");
        rd(5'h07, 8'h00, "rst2_status");
        rd(5'h02, 8'h03, "rst2_to");

`ifdef WDT_PRETIMEOUT_EN
        wr(5'h06, 8'h02);
        wr(5'h02, 8'h05); wr(5'h03, 8'h00);
        wr(5'h00, 8'h09);
        ces(2);
        chk("irq_early", wdt_irq, 1'b0);
        ces(1);
        chk("irq_set", wdt_irq, 1'b1);
        rd(5'h07, 8'h08, "irq_status");
        wr(5'h07, 8'h08);
        chk("irq_clr", wdt_irq, 1'b0);
`else
        wr(5'h06, 8'h02);
        rd(5'h06, 8'h00, "preto_absent");
        wr(5'h00, 8'h09);
        ces(3);
        chk("irq_tied", wdt_irq, 1'b0);
        rd(5'h07, 8'h00, "irq_status_absent");
`endif

        repeat (4) @(negedge clk);
        while (p_name_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: wdt_rst pulse missing (expected cycle %0d)",
                     p_name_q.pop_front(), p_cyc_q.pop_front());
        end
        while (rd_name_q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s: read never observed, expected 0x%02h",
                     rd_name_q.pop_front(), rd_exp_q.pop_front());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/wdt_windowed.md
WDT_WINDOWED -- requirements
Module: wdt_windowed

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: timeout counter width, legal 8..16.
REQ-002 SHALL have parameter DFL_TIMEOUT, default 16'h0003: TIMEOUT reset value, truncated to CNT_WIDTH.
REQ-003 SHALL have parameter DFL_EN, default 1'b0: CTRL.EN reset value.
REQ-004 SHALL have ports: clk input 1 system clock; rst input 1 reset, synchronous, active-low.
REQ-005 SHALL have ports: csr_a input 5 register address; csr_di input 8 write data; csr_we input 1 write strobe; csr_do output 8 read data.
REQ-006 SHALL have ports: wdt_ce input 1 slow-clock enable (one clk wide); wdt_rst output 1 board-reset request; wdt_irq output 1 pretimeout interrupt.

Function
REQ-007 SHALL decode map: 0x0 CTRL, 0x1 KICK, 0x2 TIMEOUT_LO, 0x3 TIMEOUT_HI, 0x4 WINDOW_LO, 0x5 WINDOW_HI, 0x6 PRETO, 0x7 STATUS; others read 0x00, writes ignored.
REQ-008 SHALL provide CTRL bits: [0] EN, [1] LOCK, [2] WMODE, [3] IRQ_EN, [7:4] read 0.
REQ-009 SHALL make LOCK set-only; while LOCK=1, writes to CTRL, TIMEOUT, WINDOW, PRETO are ignored; only reset clears LOCK.
REQ-010 SHALL register csr_do: the value for csr_a appears one clk after csr_a is presented.
REQ-011 SHALL latch a *_LO write into a shadow byte and commit LO+HI atomically on the *_HI write; bits above CNT_WIDTH are ignored and read 0.
REQ-012 SHALL treat a KICK write of 8'h6B as a kick; any other KICK value is a bad kick.
REQ-013 SHALL reload cnt with TIMEOUT on a kick, on the EN 0->1 transition, and after each timeout.
REQ-014 SHALL decrement cnt by 1 on each clk where EN=1 and wdt_ce=1 and cnt!=0; cnt holds when EN=0.
REQ-015 SHALL, on wdt_ce with EN=1 and cnt==0, flag a timeout: pulse wdt_rst high exactly one clk, set STATUS.TO, reload cnt.
REQ-016 SHALL, when WMODE=1 and a kick arrives with cnt > WINDOW, treat it as an early kick: same action as timeout, plus set STATUS.EARLY.
REQ-017 SHALL treat a bad kick while EN=1 as timeout and set STATUS.BAD; while EN=0 it is ignored.
REQ-018 SHALL give kick priority over a simultaneous wdt_ce decrement; a kick on the same clk as a cnt==0 timeout suppresses the timeout (window rules still apply).
REQ-019 SHALL provide STATUS: [0] TO, [1] EARLY, [2] BAD, [3] IRQ pending, [7:4] 0; write 1 to clear each; clear wins only if no set event that clk.
REQ-020 SHALL read back TIMEOUT/WINDOW committed values, never shadows.

Reset
REQ-021 SHALL, on clk with rst=0: EN=DFL_EN, LOCK=0, WMODE=0, IRQ_EN=0, TIMEOUT=DFL_TIMEOUT, WINDOW=all ones, PRETO=0, STATUS=0, cnt=DFL_TIMEOUT, shadows=0, csr_do=0, wdt_rst=0, wdt_irq=0.
REQ-022 SHALL abort any in-progress count or pending HI commit on reset; no wdt_rst pulse is generated by reset itself.

Configuration
REQ-023 SHALL compile the pretimeout feature only when macro WDT_PRETIMEOUT_EN is defined.
REQ-024 SHALL, with WDT_PRETIMEOUT_EN: set STATUS.IRQ when cnt decrements to value == PRETO (PRETO!=0); wdt_irq = STATUS.IRQ & IRQ_EN, registered.
REQ-025 SHALL, without WDT_PRETIMEOUT_EN: PRETO reads 0, writes ignored, STATUS[3]=0, wdt_irq tied 0.

Verification
REQ-026 SHALL cover: reset, EN=1, no kicks, wdt_ce every 100 clk -> wdt_rst single-clk pulse after 4th wdt_ce, STATUS reads 0x01.
REQ-027 SHALL cover: TIMEOUT_LO=0x10 then read 0x2 -> old value 0x03 until TIMEOUT_HI=0x00 written, then 0x10.
REQ-028 SHALL cover: WMODE=1, WINDOW=2, TIMEOUT=5, kick at cnt=4 -> wdt_rst pulse, STATUS=0x02; kick at cnt=2 -> no pulse, cnt=5.
REQ-029 SHALL cover: KICK=0x55 with EN=1 -> wdt_rst pulse, STATUS=0x04; with EN=0 -> nothing.
REQ-030 SHALL cover: CTRL=0x03 then CTRL=0x00 -> CTRL reads 0x03, counting continues until reset.
REQ-031 SHALL cover (macro defined): PRETO=2, IRQ_EN=1, TIMEOUT=5 -> wdt_irq high after 3rd wdt_ce; write STATUS=0x08 -> wdt_irq low next clk.
